// File: rtl/alu_pkg.sv
// Shared ALU types: operand/opcode widths, loader FSM states and opcode encodings.
// Imported by the operand loader and the ALU so both agree on field widths.
package alu_pkg;

  localparam int OPERAND_W = 4;
  localparam int OPCODE_W  = 3;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    ISSUE   = 2'd3
  } loader_state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_MUL = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_DIV = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b101;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Command bus from the operand loader to the ALU: A, B, opcode with valid/ready.
// Master holds the command stable while op_valid is high until op_ready is seen.
interface alu_operand_loader_if;
  import alu_pkg::*;

  logic [OPERAND_W-1:0] a_out;
  logic [OPERAND_W-1:0] b_out;
  logic [OPCODE_W-1:0]  op_out;
  logic                 op_valid;
  logic                 op_ready;

  modport master (output a_out, b_out, op_out, op_valid, input  op_ready);
  modport slave  (input  a_out, b_out, op_out, op_valid, output op_ready);

endinterface

// File: rtl/alu_operand_loader_btn_debounce.sv
// Button synchroniser + debouncer emitting a one-cycle pulse on an accepted press.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from raw level to pulse; no backpressure.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   evt_q, evt_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
    stable_d = stable_q;
    cnt_d    = '0;
    evt_d    = 1'b0;
    // Any cycle where the levels agree restarts the hold window.
    if (sync_q[SYNC_STAGES-1] != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
        evt_d    = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign btn_evt = evt_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Builds an ALU command from three debounced load presses (A, B, opcode); capture one edge after the event.
// Command is held frozen with op_valid high until op_ready; presses during ISSUE are dropped.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data_in,
  input  logic                        load_btn,
  input  logic                        clear_btn,
  alu_operand_loader_if.master        cmd,
  output logic [1:0]                  state_out
);

  logic load_evt;
  logic clear_evt;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (load_btn),
    .btn_evt (load_evt)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (clear_btn),
    .btn_evt (clear_evt)
  );

  loader_state_t        state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic [OPCODE_W-1:0]  op_q, op_d;
  logic                 valid_q, valid_d;

  logic unused_data_hi;
  assign unused_data_hi = ^data_in[7:4];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    // Clear outranks both a load press and a completing handshake.
    if (clear_evt) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_A: if (load_evt) begin
          a_d     = data_in[OPERAND_W-1:0];
          state_d = WAIT_B;
        end
        WAIT_B: if (load_evt) begin
          b_d     = data_in[OPERAND_W-1:0];
          state_d = WAIT_OP;
        end
        WAIT_OP: if (load_evt) begin
          op_d    = data_in[OPCODE_W-1:0];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: if (valid_q && cmd.op_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign cmd.a_out    = a_q;
  assign cmd.b_out    = b_q;
  assign cmd.op_out   = op_q;
  assign cmd.op_valid = valid_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for the operand loader with a short debounce window (4 cycles, 2 sync stages).
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       load_btn;
  logic       clear_btn;
  logic [1:0] state_out;

  int n_chk  = 0;
  int n_pass = 0;

  alu_operand_loader_if cmd_if ();

  alu_operand_loader #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load_btn  (load_btn),
    .clear_btn (clear_btn),
    .cmd       (cmd_if),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_cmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic v, input logic [1:0] st);
    chk({tag, "_a"}, 32'(cmd_if.a_out), 32'(a));
    chk({tag, "_b"}, 32'(cmd_if.b_out), 32'(b));
    chk({tag, "_op"}, 32'(cmd_if.op_out), 32'(op));
    chk({tag, "_vld"}, 32'(cmd_if.op_valid), 32'(v));
    chk({tag, "_st"}, 32'(state_out), 32'(st));
  endtask

  // Press sampled first at edge k; capture must land exactly at edge k+6.
  task automatic timed_press(input logic [7:0] d, input logic [1:0] st_before,
                             input logic [1:0] st_after, input string tag);
    @(negedge clk);
    data_in  = d;
    load_btn = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk({tag, "_early"}, 32'(state_out), 32'(st_before));
    @(posedge clk);
    #1 chk({tag, "_edge6"}, 32'(state_out), 32'(st_after));
    @(negedge clk);
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] d);
    @(negedge clk);
    data_in  = d;
    load_btn = 1'b1;
    repeat (8) @(negedge clk);
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic handshake();
    @(negedge clk);
    cmd_if.op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.op_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data_in = 8'h00; load_btn = 1'b0; clear_btn = 1'b0;
    cmd_if.op_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_cmd("rst", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full command build with exact capture latency
    timed_press(8'h07, 2'd0, 2'd1, "ldA");
    chk("ldA_val", 32'(cmd_if.a_out), 32'h7);
    timed_press(8'h05, 2'd1, 2'd2, "ldB");
    chk("ldB_val", 32'(cmd_if.b_out), 32'h5);
    timed_press(8'h02, 2'd2, 2'd3, "ldOp");
    chk_cmd("issue", 4'h7, 4'h5, 3'h2, 1'b1, 2'd3);

    // One-cycle ready pulse completes the handshake; fields retained
    @(negedge clk);
    cmd_if.op_ready = 1'b1;
    @(posedge clk);
    #1 chk_cmd("hs", 4'h7, 4'h5, 3'h2, 1'b0, 2'd0);
    @(negedge clk);
    cmd_if.op_ready = 1'b0;

    // Ready with no valid command does nothing
    handshake();
    chk_cmd("rdy_idle", 4'h7, 4'h5, 3'h2, 1'b0, 2'd0);

    // Two-cycle glitch is filtered, then a real press lands
    @(negedge clk);
    data_in  = 8'h0C;
    load_btn = 1'b1;
    repeat (2) @(negedge clk);
    load_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_st", 32'(state_out), 32'd0);
    chk("glitch_a", 32'(cmd_if.a_out), 32'h7);
    timed_press(8'h09, 2'd0, 2'd1, "ldA9");
    chk("ldA9_val", 32'(cmd_if.a_out), 32'h9);

    // Load presses in ISSUE are ignored
    press(8'h03);
    press(8'h04);
    chk_cmd("issue2", 4'h9, 4'h3, 3'h4, 1'b1, 2'd3);
    press(8'hFF);
    chk_cmd("issue_ign", 4'h9, 4'h3, 3'h4, 1'b1, 2'd3);
    handshake();
    chk("hs2_st", 32'(state_out), 32'd0);

    // Clear and load together in WAIT_B: clear wins
    press(8'h01);
    chk("preclr_st", 32'(state_out), 32'd1);
    @(negedge clk);
    data_in   = 8'h0B;
    load_btn  = 1'b1;
    clear_btn = 1'b1;
    repeat (8) @(negedge clk);
    load_btn  = 1'b0;
    clear_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk_cmd("clr", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

    // Upper data bits ignored; opcodes 110/111 pass through unmodified
    press(8'hF3);
    press(8'hA7);
    press(8'h0E);
    chk_cmd("mask", 4'h3, 4'h7, 3'h6, 1'b1, 2'd3);
    handshake();
    press(8'h01);
    press(8'h02);
    press(8'hFF);
    chk("op7", 32'(cmd_if.op_out), 32'h7);
    handshake();

    // Asynchronous reset mid-debounce in WAIT_OP
    press(8'h06);
    press(8'h0A);
    chk_cmd("pre_rst", 4'h6, 4'hA, 3'h7, 1'b0, 2'd2);
    @(negedge clk);
    data_in  = 8'h05;
    load_btn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    load_btn = 1'b0;
    #1 chk_cmd("arst", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk_cmd("post_rst", 4'h0, 4'h0, 3'h0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the 4-bit ALU in the tt_um top level.
- Turns a shared 8-bit switch bank and two push-buttons into a complete ALU command: operand A, operand B and a 3-bit opcode.
- Captures the three fields on three successive debounced load presses.
- Presents the finished command with a valid/ready handshake, so the ALU samples only stable, complete operands.

Parameters:
- SYNC_STAGES, 2: flops in each button synchroniser; must be ≥2.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised level must hold before it is accepted; must be ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the debounce counter; derived, not overridden.

Ports:
- clk        in   1  system clock
- rst_n      in   1  reset, asynchronous assert, active-low
- data_in    in   8  switch bank; A uses [3:0], B uses [3:0], opcode uses [2:0]
- load_btn   in   1  raw, asynchronous load button, active-high
- clear_btn  in   1  raw, asynchronous clear button, active-high
- a_out      out  4  captured operand A
- b_out      out  4  captured operand B
- op_out     out  3  captured opcode
- op_valid   out  1  command complete and held stable
- op_ready   in   1  ALU accepts the command this cycle
- state_out  out  2  current FSM state, for debug LEDs

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state WAIT_A; synchronisers, stable levels and debounce counters cleared.
- Synchroniser and debouncer, one per button:
  - The raw button passes through SYNC_STAGES flops.
  - The counter clears whenever the synchronised level equals the stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level flips and the counter clears.
  - An event is a one-cycle pulse on a stable 0→1 transition only. Release produces no event.
- Latency: a raw level held from clock edge k produces its event in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. The captured register updates at edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- FSM states, encoded on state_out:
  - WAIT_A=0: a load event captures data_in[3:0] into a_out and moves to WAIT_B.
  - WAIT_B=1: a load event captures data_in[3:0] into b_out and moves to WAIT_OP.
  - WAIT_OP=2: a load event captures data_in[2:0] into op_out and moves to ISSUE. op_valid is registered high on the same edge.
  - ISSUE=3: op_valid is held high, and a_out, b_out and op_out are frozen. When op_valid&&op_ready, op_valid drops on the next edge and the FSM returns to WAIT_A. a_out, b_out and op_out keep their values until overwritten.
- Load events in ISSUE are ignored and are not queued.
- Clear event, from any state: return to WAIT_A, zero a_out, b_out and op_out, drop op_valid.
- Clear has priority over a load event and over a handshake in the same cycle.
- op_ready while op_valid=0 has no effect.
- Opcodes 110 and 111 are captured and issued unmodified; the ALU maps them to 0.
- Data bits above the captured field are ignored.
- Reset asserted mid-sequence or mid-handshake returns every register to its reset value immediately, with no clock required.

Decomposition:
- Package alu_pkg holds:
  - state enum loader_state_t {WAIT_A, WAIT_B, WAIT_OP, ISSUE}
  - opcode constants OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_DIV=011, OP_AND=100, OP_OR=101
  - OPERAND_W=4 and OPCODE_W=3, shared with the ALU.
- One sub-module, btn_debounce, holds the synchroniser, debounce counter and rising-edge pulse. It is instantiated twice, for load and clear.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset, then three clean presses with data_in=0x07, then 0x05, then 0x02, and op_ready=0 → a_out=7, b_out=5, op_out=2, op_valid=1, state_out=3. Each capture lands exactly 6 edges after its press starts.
- From that ISSUE state, pulse op_ready for one cycle → op_valid=0 on the next edge, state_out=0, a/b/op retain 7/5/2.
- Two-cycle load glitch, then a press with data_in=0x09 → no capture from the glitch; the press gives a_out=9, state_out=1.
- In ISSUE, a load press with data_in=0xFF → a_out, b_out and op_out unchanged, op_valid stays 1.
- Clear and load stable-high in the same cycle while in WAIT_B → state_out=0, all outputs 0.
- rst_n low for half a cycle mid-debounce while in WAIT_OP → outputs 0 asynchronously. The press in progress produces no capture after reset releases.
